// File: rtl/uart_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_buf_pkg
// Brief    : Register map, status bit positions and count field offsets
//            for the UART data FIFO register block.
// Revision : 1.0
// ============================================================================
package uart_buf_pkg;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_RXDATA = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVR   = 5;

  localparam int TX_COUNT_LSB = 8;
  localparam int RX_COUNT_LSB = 16;
  localparam int COUNT_FIELD_W = 8;

endpackage
`default_nettype wire

// File: rtl/uart_data_fifo_regs_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with first-word fall-through head (masked to
//            zero while empty). A push while full is taken only if a pop
//            frees the slot in the same cycle.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);
  assign dout_o  = empty_o ? '0 : r_mem[r_rptr];

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= din_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_data_fifo_regs.sv
`default_nettype none
// ============================================================================
// Module   : uart_data_fifo_regs
// Brief    : Memory-mapped TX/RX FIFO pair between the peripheral bus and the
//            UART engines, with status word and sticky overflow flags.
// Revision : 1.0
// ============================================================================
module uart_data_fifo_regs
  import uart_buf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        addr_i,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_pop_i,
  input  logic              rx_push_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic              rx_full_o
);

  logic                        w_tx_full;
  logic                        w_tx_empty;
  logic [$clog2(TX_DEPTH):0]   w_tx_count;
  logic                        w_rx_full;
  logic                        w_rx_empty;
  logic [$clog2(RX_DEPTH):0]   w_rx_count;
  logic [DATA_W-1:0]           w_rx_head;
  logic [DATA_W-1:0]           w_status;
  logic                        w_tx_wr;
  logic                        w_tx_push;
  logic                        w_rx_pop;
  logic                        w_clr;
  logic                        r_tx_ovf;
  logic                        r_rx_ovr;

  assign w_tx_wr   = wr_i & (addr_i == ADDR_TXDATA);
  // Fullness is judged at cycle start, so a same-cycle TX pop does not make room.
  assign w_tx_push = w_tx_wr & ~w_tx_full;
  assign w_rx_pop  = rd_i & (addr_i == ADDR_RXDATA) & ~w_rx_empty;
  assign w_clr     = wr_i & (addr_i == ADDR_CLEAR);

  sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_tx_push),
    .pop_i   (tx_pop_i),
    .din_i   (wdata_i),
    .dout_o  (tx_data_o),
    .full_o  (w_tx_full),
    .empty_o (w_tx_empty),
    .count_o (w_tx_count)
  );

  sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push_i),
    .pop_i   (w_rx_pop),
    .din_i   (rx_data_i),
    .dout_o  (w_rx_head),
    .full_o  (w_rx_full),
    .empty_o (w_rx_empty),
    .count_o (w_rx_count)
  );

  assign tx_valid_o = ~w_tx_empty;
  assign rx_full_o  = w_rx_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovr <= 1'b0;
    end else begin
      if (w_tx_wr & w_tx_full)                    r_tx_ovf <= 1'b1;
      else if (w_clr & wdata_i[ST_TX_OVF])        r_tx_ovf <= 1'b0;
      if (rx_push_i & w_rx_full & ~w_rx_pop)      r_rx_ovr <= 1'b1;
      else if (w_clr & wdata_i[ST_RX_OVR])        r_rx_ovr <= 1'b0;
    end
  end

  always_comb begin
    w_status = '0;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_TX_OVF]   = r_tx_ovf;
    w_status[ST_RX_OVR]   = r_rx_ovr;
    w_status[TX_COUNT_LSB +: COUNT_FIELD_W] = COUNT_FIELD_W'(w_tx_count);
    w_status[RX_COUNT_LSB +: COUNT_FIELD_W] = COUNT_FIELD_W'(w_rx_count);
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      ADDR_RXDATA: rdata_o = w_rx_head;
      ADDR_STATUS: rdata_o = w_status;
      default:     rdata_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_data_fifo_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_data_fifo_regs
// Brief    : Directed self-checking bench for uart_data_fifo_regs.
// Revision : 1.0
// ============================================================================
module tb_uart_data_fifo_regs;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  addr_i = 2'd0;
  logic        wr_i = 1'b0;
  logic        rd_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        tx_valid_o;
  logic [31:0] tx_data_o;
  logic        tx_pop_i = 1'b0;
  logic        rx_push_i = 1'b0;
  logic [31:0] rx_data_i = '0;
  logic        rx_full_o;

  int r_checks = 0;
  int r_errors = 0;

  uart_data_fifo_regs #(.DATA_W(32), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .addr_i     (addr_i),
    .wr_i       (wr_i),
    .rd_i       (rd_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_pop_i   (tx_pop_i),
    .rx_push_i  (rx_push_i),
    .rx_data_i  (rx_data_i),
    .rx_full_o  (rx_full_o)
  );

  always #50 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_i = 1'b0; rd_i = 1'b0; tx_pop_i = 1'b0; rx_push_i = 1'b0; addr_i = 2'd0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr_i = a; wr_i = 1'b1; wdata_i = d;
    @(negedge clk_i);
    idle();
  endtask

  task automatic chk_status(input string tag, input logic [31:0] exp);
    addr_i = 2'd2;
    #1;
    chk(tag, rdata_o, exp);
    addr_i = 2'd0;
  endtask

  task automatic rx_read(input string tag, input logic [31:0] exp);
    addr_i = 2'd1; rd_i = 1'b1;
    #1;
    chk(tag, rdata_o, exp);
    @(negedge clk_i);
    idle();
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Reset state
    chk_status("reset_status", 32'h0000_000A);
    chk("reset_tx_valid", {31'd0, tx_valid_o}, 32'd0);
    chk("reset_tx_data", tx_data_o, 32'd0);
    chk("reset_rx_full", {31'd0, rx_full_o}, 32'd0);
    addr_i = 2'd1; #1 chk("reset_rdata_rx", rdata_o, 32'd0);
    addr_i = 2'd3; #1 chk("reset_rdata_clr", rdata_o, 32'd0);
    idle();

    // Writes to RXDATA / STATUS are ignored
    bus_write(2'd1, 32'h1234);
    bus_write(2'd2, 32'hFFFF_FFFF);
    chk_status("ignored_writes", 32'h0000_000A);

    // Basic TX ordering
    bus_write(2'd0, 32'h11);
    bus_write(2'd0, 32'h22);
    bus_write(2'd0, 32'h33);
    chk_status("tx3_status", 32'h0000_0308);
    chk("tx3_head", tx_data_o, 32'h11);
    tx_pop_i = 1'b1;
    #1 chk("tx_pop0", tx_data_o, 32'h11);
    @(negedge clk_i); chk("tx_pop1", tx_data_o, 32'h22);
    @(negedge clk_i); chk("tx_pop2", tx_data_o, 32'h33);
    @(negedge clk_i); chk("tx_drained_valid", {31'd0, tx_valid_o}, 32'd0);
    @(negedge clk_i); // pop while empty
    idle();
    chk_status("tx_pop_empty", 32'h0000_000A);

    // TX overflow
    for (int i = 1; i <= 8; i++) bus_write(2'd0, 32'(i));
    chk_status("tx_full", 32'h0000_0809);
    bus_write(2'd0, 32'h9);
    chk_status("tx_ovf", 32'h0000_0819);
    bus_write(2'd3, 32'h10);
    chk_status("tx_ovf_clr", 32'h0000_0809);
    chk("tx_head_intact", tx_data_o, 32'h1);
    // Full with same-cycle pop still rejects the write
    addr_i = 2'd0; wr_i = 1'b1; wdata_i = 32'hAA; tx_pop_i = 1'b1;
    @(negedge clk_i);
    idle();
    chk_status("tx_full_pop_wr", 32'h0000_0718);
    for (int i = 2; i <= 8; i++) begin
      chk($sformatf("tx_drain%0d", i), tx_data_o, 32'(i));
      tx_pop_i = 1'b1;
      @(negedge clk_i);
      tx_pop_i = 1'b0;
    end
    chk("tx_drain_valid", {31'd0, tx_valid_o}, 32'd0);
    bus_write(2'd3, 32'h10);

    // RX fill
    for (int i = 0; i < 8; i++) begin
      rx_push_i = 1'b1; rx_data_i = 32'hA0 + 32'(i);
      @(negedge clk_i);
    end
    rx_push_i = 1'b0;
    chk("rx_full_o", {31'd0, rx_full_o}, 32'd1);
    chk_status("rx_full_status", 32'h0008_0006);
    // Full with same-cycle push and pop
    rx_push_i = 1'b1; rx_data_i = 32'hB0;
    rx_read("rx_full_pushpop", 32'hA0);
    chk_status("rx_full_pushpop_st", 32'h0008_0006);
    // Overflow with a same-cycle clear: set wins
    rx_push_i = 1'b1; rx_data_i = 32'hC0;
    addr_i = 2'd3; wr_i = 1'b1; wdata_i = 32'h20;
    @(negedge clk_i);
    idle();
    chk_status("rx_ovr_set_wins", 32'h0008_0026);
    bus_write(2'd3, 32'h20);
    chk_status("rx_ovr_clr", 32'h0008_0006);
    for (int i = 1; i < 8; i++) rx_read($sformatf("rx_drain%0d", i), 32'hA0 + 32'(i));
    rx_read("rx_drain_b0", 32'hB0);
    chk_status("rx_empty", 32'h0000_000A);
    rx_read("rx_pop_empty", 32'h0);

    // Empty RX with simultaneous push and read
    rx_push_i = 1'b1; rx_data_i = 32'hAB;
    rx_read("rx_empty_pushpop", 32'h0);
    chk_status("rx_empty_pushpop_st", 32'h0001_0002);
    rx_read("rx_after_push", 32'hAB);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h50 + 32'(i));
    chk_status("tx5_status", 32'h0000_0508);
    chk("tx5_valid", {31'd0, tx_valid_o}, 32'd1);
    #20 rst_i = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, tx_valid_o}, 32'd0);
    chk("async_rst_data", tx_data_o, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_status("post_rst_status", 32'h0000_000A);

    $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
    $finish;
  end

endmodule
`default_nettype wire
